mult8_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares one sequential 8x8 multiplier between two requesters (port 0: Wishbone-side register logic, port 1: IO-pad-side logic). It accepts one operand pair at a time, issues a start pulse to the multiplier, waits for its done strobe under a watchdog, and returns the 16-bit product to the requester that issued the operation. It sits between the requester logic and `wrapped_multiplier_8` inside `user_project_wrapper`.

---
 rtl/mult8_arbiter.sv | 104 ++++++++++
 tb/tb_mult8_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult8_arbiter.sv
// rtl/mult8_arbiter.sv - round-robin sequencer sharing one sequential 8x8 multiplier between two ports
module mult8_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [1:0]  req_valid_i,
  input  logic [15:0] req_a_i,
  input  logic [15:0] req_b_i,
  output logic [1:0]  req_ready_o,
  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [15:0] rsp_prod_o,
  output logic        rsp_err_o,
  output logic        mul_start_o,
  output logic [7:0]  mul_a_o,
  output logic [7:0]  mul_b_o,
  input  logic        mul_done_i,
  input  logic [15:0] mul_prod_i,
  output logic        busy_o,
  output logic [15:0] op_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_nx;
  logic       grant_q;
  logic       last_q;
  logic       grant_sel;
  logic       req_any;
  logic       wd_expired;
  logic [7:0] wd_q;

  assign req_any    = |req_valid_i;
  assign wd_expired = (wd_q == WD_LAST);
  // Contention goes to the port that did not win last time.
  assign grant_sel  = (req_valid_i == 2'b11) ? ~last_q : req_valid_i[1];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= S_IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (req_any) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (mul_done_i || wd_expired) state_nx = S_RESP;
      S_RESP:  if (rsp_ready_i[grant_q]) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      wd_q        <= 8'd0;
      req_ready_o <= 2'b00;
      mul_start_o <= 1'b0;
      mul_a_o     <= 8'd0;
      mul_b_o     <= 8'd0;
      rsp_prod_o  <= 16'd0;
      rsp_err_o   <= 1'b0;
      op_count_o  <= 16'd0;
    end else begin
      req_ready_o <= 2'b00;
      mul_start_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            grant_q     <= grant_sel;
            last_q      <= grant_sel;
            req_ready_o <= grant_sel ? 2'b10 : 2'b01;
            mul_start_o <= 1'b1;
            mul_a_o     <= grant_sel ? req_a_i[15:8] : req_a_i[7:0];
            mul_b_o     <= grant_sel ? req_b_i[15:8] : req_b_i[7:0];
          end
        end
        S_ISSUE: wd_q <= 8'd0;
        S_WAIT: begin
          wd_q <= wd_q + 8'd1;
          // A done strobe in the expiry cycle still delivers the real product.
          if (mul_done_i) begin
            rsp_prod_o <= mul_prod_i;
            rsp_err_o  <= 1'b0;
          end else if (wd_expired) begin
            rsp_prod_o <= 16'd0;
            rsp_err_o  <= 1'b1;
          end
        end
        S_RESP: if (rsp_ready_i[grant_q]) op_count_o <= op_count_o + 16'd1;
        default: ;
      endcase
    end
  end

  assign busy_o      = (state != S_IDLE);
  assign rsp_valid_o = (state == S_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_mult8_arbiter.sv
// tb/tb_mult8_arbiter.sv - vector table, random ops against a request-level model, and corner sequences
module tb_mult8_arbiter;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_a = 16'd0;
  logic [15:0] req_b = 16'd0;
  logic [1:0]  req_ready_o;
  logic [1:0]  rsp_valid_o;
  logic [1:0]  rsp_ready = 2'b00;
  logic [15:0] rsp_prod_o;
  logic        rsp_err_o;
  logic        mul_start_o;
  logic [7:0]  mul_a_o, mul_b_o;
  logic        mul_done = 1'b0;
  logic [15:0] mul_prod = 16'd0;
  logic        busy_o;
  logic [15:0] op_count_o;

  int          checks = 0;
  int          errors = 0;
  int          last_m = 1;
  logic [15:0] cnt_m = 16'd0;
  int          mul_lat = 1;
  int          countdown = 0;
  logic [7:0]  pa = 8'd0, pb = 8'd0;

  mult8_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_prod_o(rsp_prod_o), .rsp_err_o(rsp_err_o),
    .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_done_i(mul_done), .mul_prod_i(mul_prod),
    .busy_o(busy_o), .op_count_o(op_count_o)
  );

  always #5 clk = ~clk;

  // Sequential multiplier: done strobe mul_lat cycles after start; mul_lat==0 never finishes.
  always @(negedge clk) begin
    if (!rst_n) begin
      countdown = 0;
      mul_done  = 1'b0;
    end else begin
      mul_done = 1'b0;
      if (countdown > 0) begin
        countdown = countdown - 1;
        if (countdown == 0) begin
          mul_done = 1'b1;
          mul_prod = 16'(pa) * 16'(pb);
        end
      end
      if (mul_start_o) begin
        pa = mul_a_o;
        pb = mul_b_o;
        countdown = mul_lat;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] v,
                        input logic [7:0] a0, input logic [7:0] b0,
                        input logic [7:0] a1, input logic [7:0] b1,
                        input int lat, input bit keep, input int bp,
                        input int exp_port, input logic [15:0] exp_prod, input logic exp_err);
    int n;
    int exp_lat;
    bit stable;
    logic [1:0] onehot;
    onehot  = (exp_port == 1) ? 2'b10 : 2'b01;
    exp_lat = exp_err ? TO + 1 : lat + 1;
    mul_lat   = lat;
    req_valid = v;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    rsp_ready = 2'b00;
    n = 0;
    while (req_ready_o == 2'b00 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, " grant"}, 32'(req_ready_o), 32'(onehot));
    req_valid = keep ? v : 2'b00;
    n = 0;
    while (rsp_valid_o == 2'b00 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " rsp_valid"}, 32'(rsp_valid_o), 32'(onehot));
    check({tag, " prod"}, 32'(rsp_prod_o), 32'(exp_prod));
    check({tag, " err"}, 32'(rsp_err_o), 32'(exp_err));
    if (bp > 0) begin
      stable    = 1'b1;
      req_valid = 2'b11;
      rsp_ready = ~onehot;
      repeat (bp) begin
        @(negedge clk);
        if (rsp_valid_o !== onehot || rsp_prod_o !== exp_prod || rsp_err_o !== exp_err ||
            req_ready_o !== 2'b00 || op_count_o !== cnt_m)
          stable = 1'b0;
      end
      check({tag, " backpressure stable"}, 32'(stable), 32'd1);
    end
    rsp_ready = onehot;
    req_valid = keep ? v : 2'b00;
    cnt_m     = cnt_m + 16'd1;
    @(negedge clk);
    rsp_ready = 2'b00;
    check({tag, " op_count"}, 32'(op_count_o), 32'(cnt_m));
    check({tag, " rsp_valid drop"}, 32'(rsp_valid_o), 32'd0);
  endtask

  typedef struct {
    logic [1:0] v;
    logic [7:0] a0, b0, a1, b1;
    int lat;
    bit keep;
    int bp;
    int port;
    logic [15:0] prod;
    logic err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{2'b11, 8'h03, 8'h05, 8'hFF, 8'hFF, 5,  1'b1, 0,  0, 16'h000F, 1'b0};
    tbl[1] = '{2'b11, 8'h03, 8'h05, 8'hFF, 8'hFF, 1,  1'b1, 0,  1, 16'hFE01, 1'b0};
    tbl[2] = '{2'b11, 8'h03, 8'h05, 8'hFF, 8'hFF, 9,  1'b1, 0,  0, 16'h000F, 1'b0};
    tbl[3] = '{2'b11, 8'h03, 8'h05, 8'hFF, 8'hFF, 2,  1'b0, 0,  1, 16'hFE01, 1'b0};
    tbl[4] = '{2'b01, 8'h0C, 8'h0B, 8'h00, 8'h00, 9,  1'b0, 20, 0, 16'h0084, 1'b0};
    tbl[5] = '{2'b10, 8'h44, 8'h44, 8'h00, 8'h37, 3,  1'b0, 0,  1, 16'h0000, 1'b0};
    tbl[6] = '{2'b01, 8'h21, 8'h02, 8'h00, 8'h00, 0,  1'b0, 0,  0, 16'h0000, 1'b1};
    tbl[7] = '{2'b10, 8'h00, 8'h00, 8'h12, 8'h34, TO, 1'b0, 0,  1, 16'h03A8, 1'b0};
    tbl[8] = '{2'b01, 8'h07, 8'h09, 8'h00, 8'h00, TO + 1, 1'b0, 0, 0, 16'h0000, 1'b1};
    tbl[9] = '{2'b11, 8'h02, 8'h80, 8'h81, 8'h7F, 1,  1'b0, 0,  1, 16'h3FFF, 1'b0};

    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset outputs", {req_ready_o, rsp_valid_o, rsp_err_o, mul_start_o, mul_a_o, mul_b_o}, 32'd0);
    check("reset prod/count", {rsp_prod_o, op_count_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
             tbl[i].lat, tbl[i].keep, tbl[i].bp, tbl[i].port, tbl[i].prod, tbl[i].err);
      last_m = tbl[i].port;
    end

    // Randomised operations against the request-level model.
    for (int i = 0; i < 24; i++) begin
      logic [1:0] v;
      logic [7:0] a0, b0, a1, b1;
      int lat, port, pa_m, pb_m;
      logic err;
      v  = 2'($urandom_range(1, 3));
      a0 = 8'($urandom); b0 = 8'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
      lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO + 4));
      port = (v == 2'b11) ? 1 - last_m : (v[1] ? 1 : 0);
      last_m = port;
      err  = (lat == 0) || (lat > TO);
      pa_m = (port == 1) ? int'(a1) : int'(a0);
      pb_m = (port == 1) ? int'(b1) : int'(b0);
      run_op($sformatf("rand%0d", i), v, a0, b0, a1, b1, lat, 1'b0,
             int'($urandom_range(0, 3)), port, err ? 16'h0000 : 16'(pa_m * pb_m), err);
    end

    // Reset in the middle of WAIT.
    begin
      bit seen;
      int n;
      mul_lat   = 0;
      req_valid = 2'b10;
      n = 0;
      while (req_ready_o == 2'b00 && n < 8) begin
        @(negedge clk);
        n++;
      end
      req_valid = 2'b00;
      repeat (5) @(negedge clk);
      check("midwait busy", 32'(busy_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset busy", 32'(busy_o), 32'd0);
      check("async reset operands", {16'd0, mul_a_o, mul_b_o}, 32'd0);
      check("async reset count", 32'(op_count_o), 32'd0);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      cnt_m  = 16'd0;
      last_m = 1;
      seen   = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (rsp_valid_o != 2'b00) seen = 1'b1;
      end
      check("no response after reset", 32'(seen), 32'd0);
      run_op("post-reset contention", 2'b11, 8'h06, 8'h07, 8'h09, 8'h09, 4, 1'b0, 0, 0, 16'h002A, 1'b0);
      last_m = 0;
    end

    // Counter wrap from 0xFFFF.
    force dut.op_count_o = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_o;
    cnt_m = 16'hFFFF;
    run_op("wrap", 2'b01, 8'h10, 8'h10, 8'h00, 8'h00, 2, 1'b0, 0, 0, 16'h0100, 1'b0);
    check("wrap count zero", 32'(op_count_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
